seg_display_scan: RTL and testbench

Time-multiplexed driver for a common-anode/cathode 7-segment display bank showing one calculator number. Takes the decomposed number fields (error, sign, exponent, BCD significand) for any digit count, and applies leading-zero blanking, decimal-point placement, a dedicated sign/error position and tear-free updates at frame boundaries. It sits between the calculator datapath and the board pins and replaces the per-digit combinational segment decode.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/seg_digit_select.sv | 51 +++++
 rtl/seg_display_scan.sv | 137 +++++++++++++
 tb/tb_seg_display_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
//  Module   : calc_pkg
//  Brief    : Shared display types, segment glyph constants and BCD decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  // Bit 7 = decimal point, bits 6..0 = segments a..g (a is bit 6, g is bit 0).
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'h00;
  localparam seg_t SEG_MINUS = 8'h01;
  localparam seg_t SEG_E     = 8'h4F;
  localparam seg_t SEG_DP    = 8'h80;

  // Non-decimal codes render as a minus so a corrupted digit is visible, never x.
  function automatic seg_t bcd2segments(input logic [3:0] bcd);
    seg_t seg;
    case (bcd)
      4'd0:    seg = 8'h7E;
      4'd1:    seg = 8'h30;
      4'd2:    seg = 8'h6D;
      4'd3:    seg = 8'h79;
      4'd4:    seg = 8'h33;
      4'd5:    seg = 8'h5B;
      4'd6:    seg = 8'h5F;
      4'd7:    seg = 8'h70;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h7B;
      default: seg = SEG_MINUS;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_digit_select.sv
// ============================================================================
//  Module   : seg_digit_select
//  Brief    : Glyph for one display position from the latched number fields.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_digit_select
  import calc_pkg::*;
#(
  parameter int NumDigits = 8
) (
  input  logic [$clog2(NumDigits+1)-1:0] i_pos,
  input  logic                           i_error,
  input  logic                           i_sign,
  input  logic [$clog2(NumDigits)-1:0]   i_exponent,
  input  logic [4*NumDigits-1:0]         i_significand,
  output seg_t                           o_seg
);

  localparam int PW = $clog2(NumDigits+1);

  logic [PW-1:0] w_hi;
  logic [PW-1:0] w_exp;
  logic [PW-1:0] w_limit;
  logic [3:0]    w_digit;

  always_comb begin
    w_hi    = '0;
    w_digit = 4'd0;
    w_exp   = PW'(i_exponent);
    for (int k = 0; k < NumDigits; k++) begin
      if (i_significand[4*k +: 4] != 4'd0) w_hi = PW'(k);
      if (PW'(k) == i_pos) w_digit = i_significand[4*k +: 4];
    end
    // Digits up to the decimal point stay lit so "0.005" keeps its zeros.
    w_limit = (w_exp > w_hi) ? w_exp : w_hi;

    o_seg = SEG_BLANK;
    if (i_pos == PW'(NumDigits)) begin
      if (i_error)     o_seg = SEG_E;
      else if (i_sign) o_seg = SEG_MINUS;
    end else if (!i_error && (i_pos <= w_limit)) begin
      o_seg = bcd2segments(w_digit);
      if (i_pos == w_exp) o_seg = o_seg | SEG_DP;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_scan.sv
// ============================================================================
//  Module   : seg_display_scan
//  Brief    : Time-multiplexed 7-segment scanner with frame-aligned updates.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_scan
  import calc_pkg::*;
#(
  parameter int NumDigits  = 8,
  parameter int RefreshDiv = 1000,
  parameter bit ActiveLow  = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         num_valid_i,
  input  logic                         error_i,
  input  logic                         sign_i,
  input  logic [$clog2(NumDigits)-1:0] exponent_i,
  input  logic [4*NumDigits-1:0]       significand_i,
  input  logic                         blank_i,
  output logic [7:0]                   seg_o,
  output logic [NumDigits:0]           an_o,
  output logic                         frame_o
);

  localparam int PW = $clog2(NumDigits+1);
  localparam int DW = $clog2(RefreshDiv);
  localparam int EW = $clog2(NumDigits);
  localparam int AW = NumDigits + 1;

  logic [DW-1:0]          r_div;
  logic [PW-1:0]          r_pos;

  logic                   r_pend_flag;
  logic                   r_pend_error;
  logic                   r_pend_sign;
  logic [EW-1:0]          r_pend_exponent;
  logic [4*NumDigits-1:0] r_pend_significand;

  logic                   r_disp_error;
  logic                   r_disp_sign;
  logic [EW-1:0]          r_disp_exponent;
  logic [4*NumDigits-1:0] r_disp_significand;

  seg_t                   r_seg;
  logic [AW-1:0]          r_an;
  logic                   r_frame;

  logic                   w_div_wrap;
  logic                   w_pos_last;
  logic                   w_boundary;
  seg_t                   w_seg;

  assign w_div_wrap = (r_div == DW'(RefreshDiv - 1));
  assign w_pos_last = (r_pos == PW'(NumDigits));
  assign w_boundary = w_div_wrap && w_pos_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div <= '0;
      r_pos <= '0;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + DW'(1);
      if (w_div_wrap) r_pos <= w_pos_last ? '0 : r_pos + PW'(1);
    end
  end

  // Display only changes on the boundary, so a frame never mixes two numbers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend_flag        <= 1'b0;
      r_pend_error       <= 1'b0;
      r_pend_sign        <= 1'b0;
      r_pend_exponent    <= '0;
      r_pend_significand <= '0;
      r_disp_error       <= 1'b0;
      r_disp_sign        <= 1'b0;
      r_disp_exponent    <= '0;
      r_disp_significand <= '0;
    end else begin
      if (num_valid_i) begin
        r_pend_error       <= error_i;
        r_pend_sign        <= sign_i;
        r_pend_exponent    <= exponent_i;
        r_pend_significand <= significand_i;
      end
      if (w_boundary) begin
        r_pend_flag <= 1'b0;
        if (num_valid_i) begin
          r_disp_error       <= error_i;
          r_disp_sign        <= sign_i;
          r_disp_exponent    <= exponent_i;
          r_disp_significand <= significand_i;
        end else if (r_pend_flag) begin
          r_disp_error       <= r_pend_error;
          r_disp_sign        <= r_pend_sign;
          r_disp_exponent    <= r_pend_exponent;
          r_disp_significand <= r_pend_significand;
        end
      end else if (num_valid_i) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

  seg_digit_select #(
    .NumDigits (NumDigits)
  ) u_seg_digit_select (
    .i_pos         (r_pos),
    .i_error       (r_disp_error),
    .i_sign        (r_disp_sign),
    .i_exponent    (r_disp_exponent),
    .i_significand (r_disp_significand),
    .o_seg         (w_seg)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_seg   <= SEG_BLANK;
      r_an    <= '0;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= blank_i ? SEG_BLANK : w_seg;
      r_an    <= blank_i ? '0 : (AW'(1) << r_pos);
      r_frame <= (r_div == '0) && (r_pos == '0);
    end
  end

  assign seg_o   = r_seg ^ {8{ActiveLow}};
  assign an_o    = r_an ^ {AW{ActiveLow}};
  assign frame_o = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scan.sv
// ============================================================================
//  Module   : tb_seg_display_scan
//  Brief    : Randomised bench with a frame-level reference model of the scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_scan;

  localparam int ND  = 8;
  localparam int RD  = 4;
  localparam int FRM = (ND + 1) * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        num_valid;
  logic        error;
  logic        sign;
  logic [2:0]  exponent;
  logic [31:0] significand;
  logic        blank;
  logic [7:0]  seg_o;
  logic [8:0]  an_o;
  logic        frame_o;

  int vectors = 0;
  int miss    = 0;

  seg_display_scan #(
    .NumDigits  (ND),
    .RefreshDiv (RD),
    .ActiveLow  (1'b0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .num_valid_i   (num_valid),
    .error_i       (error),
    .sign_i        (sign),
    .exponent_i    (exponent),
    .significand_i (significand),
    .blank_i       (blank),
    .seg_o         (seg_o),
    .an_o          (an_o),
    .frame_o       (frame_o)
  );

  always #5 clk = ~clk;

  // Reference: the number shown is the one in force at the start of the frame;
  // each position is rendered from the whole number, not from a digit pipeline.
  logic [7:0] glyph_tbl [16];
  initial begin
    glyph_tbl = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                  8'h7F, 8'h7B, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
  end

  function automatic logic [7:0] m_glyph(input int p, input bit e, input bit s,
                                          input int x, input logic [31:0] sig);
    int lead;
    int lim;
    logic [7:0] g;
    if (p == ND) return e ? 8'h4F : (s ? 8'h01 : 8'h00);
    if (e) return 8'h00;
    lead = 0;
    while (lead < ND - 1 && (sig >> (4 * (lead + 1))) != 0) lead++;
    lim = (x > lead) ? x : lead;
    if (p > lim) return 8'h00;
    g = glyph_tbl[(sig >> (4 * p)) & 32'hF];
    if (p == x) g = g | 8'h80;
    return g;
  endfunction

  int          n;
  bit          d_e, d_s, p_e, p_s, pflag;
  int          d_x, p_x;
  logic [31:0] d_sig, p_sig;
  logic [7:0]  exp_seg;
  logic [8:0]  exp_an;
  logic        exp_frame;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; pflag = 0;
      d_e = 0; d_s = 0; d_x = 0; d_sig = 0;
      p_e = 0; p_s = 0; p_x = 0; p_sig = 0;
      exp_seg = 0; exp_an = 0; exp_frame = 0;
    end else begin
      exp_frame = (n % FRM) == 0;
      exp_an    = blank ? 9'h000 : (9'h001 << ((n / RD) % (ND + 1)));
      exp_seg   = blank ? 8'h00 : m_glyph((n / RD) % (ND + 1), d_e, d_s, d_x, d_sig);
      if (n % FRM == FRM - 1) begin
        if (num_valid) begin
          d_e = error; d_s = sign; d_x = int'(exponent); d_sig = significand;
        end else if (pflag) begin
          d_e = p_e; d_s = p_s; d_x = p_x; d_sig = p_sig;
        end
        pflag = 0;
      end else if (num_valid) begin
        pflag = 1;
      end
      if (num_valid) begin
        p_e = error; p_s = sign; p_x = int'(exponent); p_sig = significand;
      end
      n++;
    end
  end

  always @(posedge clk) begin
    #2;
    vectors++;
    if (seg_o !== exp_seg) begin
      miss++;
      $display("FAIL seg t=%0t: seg_o=%h required %h", $time, seg_o, exp_seg);
    end
    if (an_o !== exp_an) begin
      miss++;
      $display("FAIL an t=%0t: an_o=%h required %h", $time, an_o, exp_an);
    end
    if (frame_o !== exp_frame) begin
      miss++;
      $display("FAIL frame t=%0t: frame_o=%b required %b", $time, frame_o, exp_frame);
    end
  end

  task automatic lit(input int p, input logic [7:0] want, input string nm);
    int i;
    i = 0;
    @(negedge clk);
    while (an_o !== (9'h001 << p) && i < 2 * FRM) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (an_o !== (9'h001 << p)) begin
      miss++;
      $display("FAIL %s: position %0d never selected, an_o=%h", nm, p, an_o);
    end else if (seg_o !== want) begin
      miss++;
      $display("FAIL %s: seg_o=%h required %h", nm, seg_o, want);
    end
  endtask

  task automatic load(input bit e, input bit s, input logic [2:0] x, input logic [31:0] sig);
    @(negedge clk);
    error = e; sign = s; exponent = x; significand = sig; num_valid = 1'b1;
    @(negedge clk);
    num_valid = 1'b0;
  endtask

  task automatic wait_boundary();
    int i;
    i = 0;
    while (n % FRM != FRM - 1 && i < 2 * FRM) begin
      @(negedge clk);
      i++;
    end
  endtask

  initial begin
    rst = 1'b1; num_valid = 0; error = 0; sign = 0; exponent = 0; significand = 0; blank = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (seg_o !== 8'hFE || an_o !== 9'h001 || frame_o !== 1'b1) begin
      miss++;
      $display("FAIL reset_first: seg=%h an=%h frame=%b required fe 001 1", seg_o, an_o, frame_o);
    end
    lit(5, 8'h00, "reset_pos5_blank");
    lit(8, 8'h00, "reset_sign_blank");
    repeat (2 * FRM) @(negedge clk);

    load(0, 1, 3'd0, 32'h0000_1234);
    repeat (FRM + 2) @(negedge clk);
    lit(0, 8'hB3, "t1_digit0_dp");
    lit(3, 8'h30, "t1_digit3");
    lit(5, 8'h00, "t1_digit5_blank");
    lit(8, 8'h01, "t1_minus");

    load(0, 0, 3'd3, 32'h0000_0005);
    repeat (FRM + 2) @(negedge clk);
    lit(0, 8'h5B, "t2_digit0");
    lit(3, 8'hFE, "t2_digit3_dp");
    lit(4, 8'h00, "t2_digit4_blank");

    load(1, 0, 3'd2, 32'h0000_1234);
    repeat (FRM + 2) @(negedge clk);
    lit(0, 8'h00, "t3_err_digit0");
    lit(8, 8'h4F, "t3_err_E");

    // Two mid-frame captures then one on the boundary cycle: only the last shows.
    repeat (5) @(negedge clk);
    load(0, 0, 3'd1, 32'h0000_0077);
    load(0, 1, 3'd0, 32'h0000_0088);
    wait_boundary();
    error = 0; sign = 0; exponent = 3'd0; significand = 32'h0000_0009; num_valid = 1'b1;
    @(negedge clk);
    num_valid = 1'b0;
    lit(0, 8'hFB, "t4_boundary_bypass");
    lit(1, 8'h00, "t4_digit1_blank");

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      num_valid = ($urandom_range(0, 9) == 0);
      error     = ($urandom_range(0, 7) == 0);
      sign      = $urandom_range(0, 1);
      exponent  = 3'($urandom_range(0, 7));
      significand = $urandom() >> (4 * $urandom_range(0, 8));
      if (c % 97 == 40) blank = 1'b1;
      if (c % 97 == 50) blank = 1'b0;
    end
    num_valid = 1'b0;
    blank = 1'b0;

    repeat (13) @(negedge clk);
    blank = 1'b1;
    repeat (10) @(negedge clk);
    blank = 1'b0;
    repeat (7) @(negedge clk);
    load(0, 1, 3'd0, 32'h0000_0042);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (seg_o !== 8'hFE || an_o !== 9'h001 || frame_o !== 1'b1) begin
      miss++;
      $display("FAIL reset_mid: seg=%h an=%h frame=%b required fe 001 1", seg_o, an_o, frame_o);
    end
    repeat (FRM + 2) @(negedge clk);
    lit(8, 8'h00, "reset_discards_pending");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

`default_nettype wire
